// File: rtl/bus_pkg.sv
// Shared definitions for the per-terminal bus endpoint: ID field width,
// broadcast default and destination extraction.
package bus_pkg;

  localparam int ID_W = 8;
  localparam int MAX_W = 256;
  localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

  typedef logic [ID_W-1:0] bus_id_t;

  // Destination ID lives in the top byte of a w-bit packet.
  function automatic bus_id_t get_dest(input logic [MAX_W-1:0] word, input int unsigned w);
    return ID_W'(word >> (w - ID_W));
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy; a write and a read
// in the same cycle both take effect even when full.
module bus_fifo #(
  parameter int width       = 32,
  parameter int profundidad = 16
) (
  input  logic                               clk_i,
  input  logic                               reset,
  input  logic                               wr,
  input  logic [width-1:0]                   wr_data,
  input  logic                               rd,
  output logic                               full,
  output logic                               empty,
  output logic [width-1:0]                   head,
  output logic [$clog2(profundidad+1)-1:0]   count
);

  localparam int AW = (profundidad > 1) ? $clog2(profundidad) : 1;
  localparam int CW = $clog2(profundidad + 1);

  logic [width-1:0] mem [profundidad];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(profundidad - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(profundidad));
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);
  // Head reads as zero when empty so stale storage never leaks out after reset.
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (rd_ok) rd_ptr <= nxt(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bus_endpoint.sv
// Bus terminal endpoint: TX queue toward the bus, address-filtered RX queue
// toward the device, saturating drop/misroute counters and sticky pop error.
module bus_endpoint import bus_pkg::*; #(
  parameter int      width       = 32,
  parameter int      profundidad = 16,
  parameter bus_id_t ID          = 8'h00,
  parameter bus_id_t broadcast   = BCAST_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset,
  output logic             pndng,
  output logic [width-1:0] D_pop,
  input  logic             pop,
  input  logic             push,
  input  logic [width-1:0] D_push,
  input  logic             tx_wr,
  input  logic [width-1:0] tx_data,
  output logic             tx_full,
  output logic             rx_valid,
  output logic [width-1:0] rx_data,
  input  logic             rx_rd,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      misroute_cnt,
  output logic             err_pop
);

  localparam int CW = $clog2(profundidad + 1);

  logic          tx_empty;
  logic          rx_empty;
  logic          rx_full;
  logic [CW-1:0] unused_tx_count;
  logic [CW-1:0] unused_rx_count;
  bus_id_t       dest;
  logic          addr_hit;
  logic          accept;
  logic          misroute;
  logic          drop;

  bus_fifo #(.width(width), .profundidad(profundidad)) tx_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .head    (D_pop),
    .count   (unused_tx_count)
  );

  bus_fifo #(.width(width), .profundidad(profundidad)) rx_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .wr      (accept),
    .wr_data (D_push),
    .rd      (rx_rd),
    .full    (rx_full),
    .empty   (rx_empty),
    .head    (rx_data),
    .count   (unused_rx_count)
  );

  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  assign dest     = get_dest(MAX_W'(D_push), width);
  assign addr_hit = (dest == ID) || (dest == broadcast);
  assign accept   = push && addr_hit;
  assign misroute = push && !addr_hit;
  // A full RX FIFO still accepts when the device reads in the same cycle.
  assign drop     = accept && rx_full && !rx_rd;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      drop_cnt     <= '0;
      misroute_cnt <= '0;
      err_pop      <= 1'b0;
    end else begin
      if (drop && (drop_cnt != 16'hFFFF))         drop_cnt     <= drop_cnt + 16'd1;
      if (misroute && (misroute_cnt != 16'hFFFF)) misroute_cnt <= misroute_cnt + 16'd1;
      if (pop && tx_empty)                        err_pop      <= 1'b1;
    end
  end

endmodule
